// File: rtl/uart_rx_oversample_if.sv
// Signal bundle for uart_rx_oversample: the serial line in, the received word and status out.
// The slave modport is the receiver; the master modport is whatever drives the line and consumes words.
interface uart_rx_oversample_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] out;
  logic                 outclk;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (output rxd, input out, outclk, frame_err, parity_err, busy);
  modport slave  (input rxd, output out, outclk, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: samples each bit at its centre, LSB-first, with framing and break handling.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx_oversample #(
  parameter int CYCLES_PER_BIT = 10,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_ODD     = 0
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_oversample_if.slave bus
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  if (CYCLES_PER_BIT < 4 || (CYCLES_PER_BIT % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_oversample: illegal parameter value");
  end

  logic                 sync1_q, sync2_q;
  logic                 srx;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 outclk_q, outclk_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign srx = sync2_q;

  // Every bit period after START counts a full bit; START counts only half so sampling lands mid-bit.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    out_d       = out_q;
    outclk_d    = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!srx) begin
          state_d = START;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          state_d = srx ? IDLE : DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {srx, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          par_d   = srx;
          state_d = STOP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d       = '0;
          bit_d       = '0;
          out_d       = shift_q;
          outclk_d    = 1'b1;
          frame_err_d = !srx;
`ifdef UART_RX_PARITY_EN
          parity_err_d = ((^shift_q) ^ par_q) != (PARITY_ODD != 0);
`endif
          state_d     = srx ? IDLE : BREAK;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      BREAK: begin
        if (srx) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sync flops reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      out_q       <= '0;
      outclk_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= bus.rxd;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      outclk_q    <= outclk_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.outclk    = outclk_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: frames are driven bit by bit, expected words and strobe
// cycles are queued at the start bit and popped whenever the receiver strobes outclk.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  localparam int CPB     = 10;
  localparam int DBITS   = 8;
  localparam int PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Falling edge driven at a negedge: 1 cycle to the first posedge, 2 sync cycles, half a bit,
  // then data, parity and stop bits; the strobe is seen at the negedge after the stop sample.
  localparam int STROBE_LAT = 3 + CPB / 2 + (DBITS + PAR_BITS + 1) * CPB;

  typedef struct {
    logic [DBITS-1:0] data;
    logic             fe;
    logic             pe;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  uart_rx_oversample_if #(.DATA_BITS(DBITS)) bus ();

  uart_rx_oversample #(
    .CYCLES_PER_BIT(CPB),
    .DATA_BITS     (DBITS),
    .PARITY_ODD    (PAR_ODD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic goodParity(input logic [DBITS-1:0] d);
    return (^d) ^ (PAR_ODD != 0);
  endfunction

  // Called at a negedge; returns at a negedge with the stop level still on the line.
  task automatic applyStimulus(input logic [DBITS-1:0] data, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.data = data;
    e.fe   = !stop_bit;
    e.pe   = (PAR_BITS != 0) ? (((^data) ^ par_bit) != (PAR_ODD != 0)) : 1'b0;
    e.cyc  = cyc + STROBE_LAT;
    sb.push_back(e);
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DBITS; i++) begin
      bus.rxd = data[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_BITS != 0) begin
      bus.rxd = par_bit;
      repeat (CPB) @(negedge clk);
    end
    bus.rxd = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.outclk) begin
      checkOutput("strobe_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("out", 32'(bus.out), 32'(e.data));
        checkOutput("frame_err", 32'(bus.frame_err), 32'(e.fe));
        checkOutput("parity_err", 32'(bus.parity_err), 32'(e.pe));
        checkOutput("strobe_cycle", cyc, e.cyc);
      end
    end else if (bus.frame_err || bus.parity_err) begin
      checkOutput("stray_err_strobe", {30'd0, bus.frame_err, bus.parity_err}, 32'd0);
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    rst     = 1'b1;
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_out", 32'(bus.out), 32'd0);
    checkOutput("reset_outclk", 32'(bus.outclk), 32'd0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 32'd0);
    checkOutput("reset_parity_err", 32'(bus.parity_err), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, goodParity(8'hA5));
    checkOutput("busy_after_frame", 32'(bus.busy), 32'd0);
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] back-to-back 0x3C, 0xC3");
    applyStimulus(8'h3C, 1'b1, goodParity(8'h3C));
    applyStimulus(8'hC3, 1'b1, goodParity(8'hC3));
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] 3-cycle glitch");
    bus.rxd = 1'b0;
    repeat (3) @(negedge clk);
    bus.rxd = 1'b1;
    @(negedge clk);
    checkOutput("glitch_busy_high", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.busy && n < CPB / 2 + 2) begin
      @(negedge clk);
      n++;
    end
    checkOutput("glitch_busy_low", 32'(bus.busy), 32'd0);
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] 0x55 with stop=0 then line held low");
    applyStimulus(8'h55, 1'b0, goodParity(8'h55));
    repeat (40) @(negedge clk);
    checkOutput("break_busy", 32'(bus.busy), 32'd1);
    bus.rxd = 1'b1;
    n = 0;
    while (bus.busy && n < 4) begin
      @(negedge clk);
      n++;
    end
    checkOutput("break_exit", 32'(bus.busy), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    applyStimulus(8'h9A, 1'b1, goodParity(8'h9A));
    repeat (2 * CPB) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames 0x07");
    applyStimulus(8'h07, 1'b1, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
`endif

    $display("[TB] reset during data bit 4 of 0xFF");
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    checkOutput("busy_mid_frame", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_out", 32'(bus.out), 32'd0);
    checkOutput("midreset_outclk", 32'(bus.outclk), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    applyStimulus(8'h12, 1'b1, goodParity(8'h12));
    repeat (2 * CPB) @(negedge clk);

    n = 0;
    while (sb.size() > 0 && n < 2 * STROBE_LAT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter CYCLES_PER_BIT, default 10: clk cycles per bit; legal range >=4, even.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when parity is compiled in.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port rxd  input  1  raw serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port out  output  DATA_BITS  last received data word, LSB = first bit on the line.
REQ-008 SHALL have port outclk  output  1  one-cycle strobe, high when out is updated.
REQ-009 SHALL have port frame_err  output  1  one-cycle strobe, coincident with outclk, high when the stop bit sampled 0.
REQ-010 SHALL have port parity_err  output  1  one-cycle strobe, coincident with outclk, high on parity mismatch.
REQ-011 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer (srx); all decisions use srx; latency from rxd to srx is 2 cycles.
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-014 IDLE SHALL move to START on the edge where srx is first sampled 0; call this edge N.
REQ-015 START SHALL resample srx at edge N+CYCLES_PER_BIT/2: if 0, go to DATA; if 1, return to IDLE with no strobe (glitch reject).
REQ-016 DATA SHALL sample data bit i (i=0..DATA_BITS-1) at edge N+CYCLES_PER_BIT/2+(i+1)*CYCLES_PER_BIT and shift it in LSB-first.
REQ-017 PARITY SHALL occur only when parity is compiled in, and SHALL sample one extra bit, CYCLES_PER_BIT after the last data bit.
REQ-018 STOP SHALL sample srx CYCLES_PER_BIT after the previous bit; call this edge S.
REQ-019 During the cycle after edge S, outclk SHALL be 1 and out SHALL hold the shifted word; this holds regardless of frame or parity errors.
REQ-020 frame_err SHALL be 1 in that same cycle if the stop sample was 0.
REQ-021 out SHALL hold its value until the next outclk.
REQ-022 After STOP, a stop sample of 1 SHALL return to IDLE; a stop sample of 0 SHALL enter BREAK.
REQ-023 BREAK SHALL stay until srx=1, then go to IDLE; no new frame can start while in BREAK.
REQ-024 A start edge arriving on the cycle IDLE is re-entered SHALL be detected (back-to-back frames, no dead cycle required).
REQ-025 The bit counter SHALL be clog2(DATA_BITS+1) wide and the cycle counter clog2(CYCLES_PER_BIT) wide; neither counter shall wrap mid-frame.
REQ-026 outclk, frame_err and parity_err SHALL each be 0 in all cycles other than the one described in REQ-019.

Reset
REQ-027 rst high SHALL immediately set: state=IDLE, out=0, outclk=0, frame_err=0, parity_err=0, busy=0, both sync flops=1, all counters=0.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no strobe.
REQ-029 After rst is released, a frame SHALL be received only from a new falling edge.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL exist and parity_err SHALL be 1 when (XOR of data bits ^ parity bit) != PARITY_ODD.
REQ-031 With UART_RX_PARITY_EN undefined, the PARITY state SHALL be absent, frames SHALL be 1+DATA_BITS+1 bits, and parity_err SHALL be tied 0.

Verification
REQ-032 Defaults, no parity, send 0xA5 with stop=1 -> outclk one cycle at edge N+96, out=0xA5, frame_err=0, busy low after.
REQ-033 Send 0x3C then 0xC3 back-to-back, no idle gap -> two outclk strobes 100 cycles apart, out=0x3C then 0xC3.
REQ-034 Pull rxd low for 3 cycles, then high -> no outclk, busy returns 0 within CYCLES_PER_BIT/2+3 cycles.
REQ-035 Send 0x55 with stop=0, hold rxd low for 40 more cycles -> outclk and frame_err high together, out=0x55, no new frame until rxd returns high.
REQ-036 UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1, out=0x07; same byte with parity bit 1 -> parity_err=0.
REQ-037 Assert rst at data bit 4 of 0xFF, release it, then send 0x12 -> no strobe for 0xFF, then out=0x12 with exactly one outclk.
